// File: rtl/seq_edge_8b_pos_detect_pkg.sv
// Shared constants and helpers for the per-bit rising-edge detector.
package seq_edge_8b_pos_detect_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bits that are 1 now and were 0 one sample earlier.
  function automatic logic [DEFAULT_WIDTH-1:0] rise_mask(
    input logic [DEFAULT_WIDTH-1:0] cur,
    input logic [DEFAULT_WIDTH-1:0] prev
  );
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/seq_edge_8b_pos_detect_dff_rst.sv
// Parameterised-width D flip-flop with synchronous active-high reset to zero.
module dff_rst
  import seq_edge_8b_pos_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: non-blocking assignment, so every register samples pre-edge values.
  // NOTE: reset is sampled on the clock edge and clears the whole register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_edge_8b_pos_detect.sv
// Per-bit 0->1 edge detector: out[i] pulses for one cycle after in_[i] rises.
module seq_edge_8b_pos_detect
  import seq_edge_8b_pos_detect_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;

  dff_rst #(.WIDTH(WIDTH)) u_prev (
    .clk   (clk),
    .reset (reset),
    .d     (in_),
    .q     (prev_q)
  );

  // Registered output keeps in_ off any combinational path to out.
  assign rise = in_ & ~prev_q;

  dff_rst #(.WIDTH(WIDTH)) u_out (
    .clk   (clk),
    .reset (reset),
    .d     (rise),
    .q     (out)
  );

endmodule

// File: tb/tb_seq_edge_8b_pos_detect.sv
// Directed and random checks for the 8-bit rising-edge detector.
module tb_seq_edge_8b_pos_detect;

  logic       clk;
  logic       reset;
  logic [7:0] in_;
  logic [7:0] out;

  int checks   = 0;
  int failures = 0;

  seq_edge_8b_pos_detect dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // Drive v before the edge, sample out 1 time unit after it.
  task automatic step(input string tag, input logic [7:0] v,
                      input logic [7:0] exp, input bit do_check);
    in_ = v;
    @(posedge clk);
    #1;
    if (do_check) check(tag, out, exp);
  endtask

  task automatic do_reset(input logic [7:0] v);
    reset = 1'b1;
    in_   = v;
    @(posedge clk);
    #1;
    check("reset_out", out, 8'h00);
    reset = 1'b0;
  endtask

  logic [7:0] tog_in  [8]  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
  logic [7:0] tog_exp [8]  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
  logic [7:0] hold_in [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01,
                               8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] hold_exp[13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] mb_in   [11] = '{8'h00, 8'h00, 8'hAA, 8'h00, 8'hAA, 8'h55,
                               8'hFF, 8'h55, 8'hFF, 8'h00, 8'hAA};
  logic [7:0] mb_exp  [11] = '{8'h00, 8'h00, 8'hAA, 8'h00, 8'hAA, 8'h55,
                               8'hAA, 8'h00, 8'hAA, 8'h00, 8'hAA};
  logic [7:0] mx_in   [9]  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h55, 8'h11,
                               8'h44, 8'h00, 8'h00};
  logic [7:0] mx_exp  [9]  = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h44, 8'h00,
                               8'h44, 8'h00, 8'h00};

  initial begin
    logic [7:0] prev_m;
    logic [7:0] v;

    reset = 1'b1;
    in_   = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", out, 8'h00);
    reset = 1'b0;

    // Single-bit toggle; first post-reset cycle is not checked.
    for (int i = 0; i < 8; i++)
      step($sformatf("toggle[%0d]", i), tog_in[i], tog_exp[i], i > 0);

    do_reset(8'h00);
    for (int i = 0; i < 13; i++)
      step($sformatf("hold[%0d]", i), hold_in[i], hold_exp[i], i > 0);

    do_reset(8'h00);
    for (int i = 0; i < 11; i++)
      step($sformatf("multi[%0d]", i), mb_in[i], mb_exp[i], i > 0);

    do_reset(8'h00);
    for (int i = 0; i < 9; i++)
      step($sformatf("mixed[%0d]", i), mx_in[i], mx_exp[i], i > 0);

    // Input held high through reset counts as a rise once reset drops.
    do_reset(8'hFF);
    step("rst_ff_rise", 8'hFF, 8'hFF, 1'b1);
    step("rst_ff_after", 8'hFF, 8'h00, 1'b1);

    // A pending flag is discarded by reset.
    step("pend_low", 8'h00, 8'h00, 1'b1);
    step("pend_rise", 8'h0F, 8'h0F, 1'b1);
    reset = 1'b1;
    step("pend_cleared", 8'h0F, 8'h00, 1'b1);
    reset = 1'b0;
    step("pend_rerise", 8'h0F, 8'h0F, 1'b1);
    step("pend_steady", 8'h0F, 8'h00, 1'b1);

    // Random vectors against out(n+1) = in_(n) & ~in_(n-1).
    do_reset(8'h00);
    prev_m = 8'h00;
    for (int i = 0; i < 60; i++) begin
      v = 8'($urandom);
      step($sformatf("rand[%0d]", i), v, v & ~prev_m, 1'b1);
      prev_m = v;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
